// File: rtl/spike_tx.sv
// spike_tx: captures node result words on in_rdy rising edges, queues them in a FIFO and
// serialises each as a framed one-wire word. Define PARITY_EN to add an even-parity bit per frame.
module spike_tx #(
    parameter int DEPTH     = 4,
    parameter int DIV       = 4,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_data,
    input  logic       in_rdy,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic [7:0] drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // Handshake: in_rdy is a level with no backpressure; a word is offered on every 0->1
    // transition of in_rdy and in_data is sampled in that cycle. A full FIFO drops it.
    logic              rdy_q;
    logic              push;
    logic              pop;
    logic              do_write;
    logic              fifo_empty;
    logic [3:0]        mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    assign push       = in_rdy & ~rdy_q & (!SKIP_ZERO || (in_data != 4'd0));
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign do_write   = push & (~fifo_full | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= 8'd0;
        end else begin
            rdy_q <= in_rdy;
            if (do_write) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)      rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push && !do_write && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr[AW-1:0]] <= in_data;
    end

    state_t          state;
    state_t          state_d;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_d;
    logic [1:0]      bit_idx;
    logic [1:0]      bit_idx_d;
    logic [3:0]      word;
    logic [3:0]      word_d;
    logic            tx_d;
    logic            t_done;

    assign t_done = (timer == T_LAST);
    assign busy   = (state != S_IDLE) | ~fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= 2'd0;
            word    <= 4'd0;
            tx      <= 1'b1;
        end else begin
            state   <= state_d;
            timer   <= timer_d;
            bit_idx <= bit_idx_d;
            word    <= word_d;
            tx      <= tx_d;
        end
    end

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (t_done) state_d = S_DATA;
            end
            S_DATA: begin
                if (t_done && (bit_idx == 2'd3)) begin
`ifdef PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef PARITY_EN
            S_PARITY: begin
                if (t_done) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                // Chain straight into the next frame when a word is waiting.
                if (t_done) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        timer_d   = (state_d != state || t_done) ? '0 : timer + TW'(1);
        bit_idx_d = bit_idx;
        if (state_d != S_DATA)
            bit_idx_d = 2'd0;
        else if (state == S_DATA && t_done)
            bit_idx_d = bit_idx + 2'd1;
        word_d = pop ? mem[rd_ptr[AW-1:0]] : word;
        case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = word_d[bit_idx_d];
`ifdef PARITY_EN
            S_PARITY: tx_d = ^word_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_spike_tx.sv
// Bench for spike_tx: two instances (SKIP_ZERO=1 and 0) share random stimulus and are checked
// every cycle against a frame-level reference model built on word queues.
module tb_spike_tx;
    localparam int DEPTH = 4;
    localparam int DIV   = 4;
`ifdef PARITY_EN
    localparam int NBITS = 7;
`else
    localparam int NBITS = 6;
`endif
    localparam int FRAME = NBITS * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_rdy = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic [1:0] tx_w;
    logic [1:0] busy_w;
    logic [1:0] full_w;
    logic [7:0] drop_w [2];

    int n_vec = 0;
    int n_err = 0;

    spike_tx #(.DEPTH(DEPTH), .DIV(DIV), .SKIP_ZERO(1'b1)) dut_skip (
        .clk(clk), .rst(rst), .in_data(in_data), .in_rdy(in_rdy),
        .tx(tx_w[0]), .busy(busy_w[0]), .fifo_full(full_w[0]), .drop_cnt(drop_w[0])
    );

    spike_tx #(.DEPTH(DEPTH), .DIV(DIV), .SKIP_ZERO(1'b0)) dut_all (
        .clk(clk), .rst(rst), .in_data(in_data), .in_rdy(in_rdy),
        .tx(tx_w[1]), .busy(busy_w[1]), .fifo_full(full_w[1]), .drop_cnt(drop_w[1])
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: one word queue per instance plus the remaining length of the frame on the wire
    logic [3:0] exp_q0[$];
    logic [3:0] exp_q1[$];
    int         frame_left [2] = '{0, 0};
    logic [3:0] cur_word [2] = '{4'd0, 4'd0};
    int         m_drop [2] = '{0, 0};
    logic       m_rdy_q = 1'b0;

    function automatic int q_size(input int k);
        return (k == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [3:0] q_pop(input int k);
        return (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    endfunction

    function automatic void q_push(input int k, input logic [3:0] w);
        if (k == 0) exp_q0.push_back(w);
        else        exp_q1.push_back(w);
    endfunction

    function automatic logic exp_tx(input int k);
        int slot;
        if (frame_left[k] == 0) return 1'b1;
        slot = (FRAME - frame_left[k]) / DIV;
        if (slot == 0) return 1'b0;
        if (slot <= 4) return cur_word[k][slot-1];
`ifdef PARITY_EN
        if (slot == 5) return ^cur_word[k];
`endif
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        logic rise;
        rise = in_rdy && !m_rdy_q;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                if (k == 0) exp_q0.delete();
                else        exp_q1.delete();
                frame_left[k] = 0;
                m_drop[k]     = 0;
            end else begin
                logic push;
                logic pop;
                push = rise && (k == 1 || in_data != 4'd0);
                pop  = (q_size(k) > 0) && (frame_left[k] <= 1);
                if (push && q_size(k) == DEPTH && !pop && m_drop[k] < 255) m_drop[k]++;
                if (pop) begin
                    cur_word[k]   = q_pop(k);
                    frame_left[k] = FRAME;
                end else if (frame_left[k] > 0) begin
                    frame_left[k]--;
                end
                if (push && q_size(k) < DEPTH) q_push(k, in_data);
            end
        end
        m_rdy_q = rst ? 1'b0 : in_rdy;
    end

    // scoreboard check
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // driver: compare outputs after the last edge, then apply inputs for the next edge
    task automatic tick(input logic r, input logic rdy, input logic [3:0] d);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("tx%0d", k),   {7'd0, tx_w[k]},   {7'd0, exp_tx(k)});
            check($sformatf("busy%0d", k), {7'd0, busy_w[k]},
                  {7'd0, (frame_left[k] > 0 || q_size(k) > 0)});
            check($sformatf("full%0d", k), {7'd0, full_w[k]}, {7'd0, (q_size(k) == DEPTH)});
            check($sformatf("drop%0d", k), drop_w[k], 8'(m_drop[k]));
        end
        rst     = r;
        in_rdy  = rdy;
        in_data = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        tick(1'b1, 1'b0, 4'd0);
        tick(1'b1, 1'b0, 4'd0);

        // single word 0x5
        tick(1'b0, 1'b1, 4'h5);
        tick(1'b0, 1'b1, 4'h5);
        idle(30);

        // three words, frames chained
        tick(1'b0, 1'b1, 4'h1);
        tick(1'b0, 1'b0, 4'h1);
        tick(1'b0, 1'b1, 4'h2);
        tick(1'b0, 1'b0, 4'h2);
        tick(1'b0, 1'b1, 4'h3);
        idle(90);

        // six captures during the first frame: one overflow drop
        for (int i = 1; i <= 6; i++) begin
            tick(1'b0, 1'b1, 4'(i));
            tick(1'b0, 1'b0, 4'(i));
        end
        idle(150);

        // zero word: only the non-filtering instance sends it
        tick(1'b0, 1'b1, 4'h0);
        idle(40);

        // reset in the middle of data bit 2
        tick(1'b0, 1'b1, 4'hA);
        idle(13);
        tick(1'b1, 1'b0, 4'd0);
        idle(40);

        // in_rdy high across reset release counts as a rising edge
        tick(1'b1, 1'b1, 4'h9);
        tick(1'b0, 1'b1, 4'h9);
        idle(40);

        // random traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            logic       r;
            logic       rdy;
            logic [3:0] d;
            r   = ($urandom_range(0, 499) == 0);
            rdy = ($urandom_range(0, 2) == 0) ? ~in_rdy : in_rdy;
            d   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            tick(r, rdy, d);
        end

        // sustained overflow until drop_cnt saturates
        tick(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 800; i++)
            tick(1'b0, 1'(i % 2), 4'($urandom_range(1, 15)));
        @(negedge clk);
        check("drop_sat0", drop_w[0], 8'd255);
        check("drop_sat1", drop_w[1], 8'd255);
        idle(150);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
